// File: rtl/cpu_completion_md_if.sv
// Stage-4 completion bus.
// The pipeline side (master) drives the stage-4 register contents and
// memory status, and receives the writeback value and the pipeline stall.
// The completion unit (slave) sees the same signals in the opposite direction.
//   p4_op            opcode of the instruction in stage 4
//   p4_alu_out       ALU result
//   p4_lhs, p4_rhs   source operands for mul/div
//   p4_addr_lo       low address bits of a load
//   p4_write_pending store not yet accepted by memory
//   p4_read_pending  load data not yet returned
//   p4_mem_rdata     little-endian load data word
//   p4_data_out      writeback value
//   stall            hold stages 1-4 this cycle
interface cpu_completion_md_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       p4_op;
    logic [WIDTH-1:0] p4_alu_out;
    logic [WIDTH-1:0] p4_lhs;
    logic [WIDTH-1:0] p4_rhs;
    logic [1:0]       p4_addr_lo;
    logic             p4_write_pending;
    logic             p4_read_pending;
    logic [WIDTH-1:0] p4_mem_rdata;
    logic [WIDTH-1:0] p4_data_out;
    logic             stall;

    modport master (
        output p4_op, p4_alu_out, p4_lhs, p4_rhs, p4_addr_lo,
               p4_write_pending, p4_read_pending, p4_mem_rdata,
        input  p4_data_out, stall
    );

    modport slave (
        input  p4_op, p4_alu_out, p4_lhs, p4_rhs, p4_addr_lo,
               p4_write_pending, p4_read_pending, p4_mem_rdata,
        output p4_data_out, stall
    );
endinterface

// File: rtl/cpu_completion_md.sv
// Pipeline stage-4 completion unit.
// Selects the register-file writeback value (ALU result, extracted and
// extended load data, or a multi-cycle mul/div result) and raises stall
// while a memory transaction or an arithmetic operation is outstanding.
//   clock  single clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    stage-4 completion bus (slave side)
//
// state | meaning
// IDLE  | no arithmetic in flight; mul/div opcode captures operands
// MUL   | product held, timing out MUL_CYCLES stall cycles
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result on p4_data_out for one cycle, stall released
module cpu_completion_md #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    cpu_completion_md_if.slave   bus
);
    localparam logic [5:0] OP_LDW  = 6'h10, OP_LDB  = 6'h11, OP_LDBU = 6'h12,
                           OP_LDH  = 6'h13, OP_LDHU = 6'h14;
    localparam logic [5:0] OP_STW  = 6'h18, OP_STB  = 6'h19, OP_STH  = 6'h1A;
    localparam logic [5:0] OP_MUL  = 6'h20, OP_DIVU = 6'h21, OP_DIVS = 6'h22,
                           OP_MODU = 6'h23, OP_MODS = 6'h24;

    localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3;

    localparam int HW = WIDTH / 2;
    localparam int CW = ($clog2(WIDTH) > 3) ? $clog2(WIDTH) : 3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] rem_q, quo_q, divisor_q;
    logic             is_mod_q, q_neg_q, r_neg_q;

    // operand decode for the capture cycle
    logic             is_mul, is_div, op_signed, op_mod;
    logic             lhs_neg, rhs_neg;
    logic [WIDTH-1:0] lhs_mag, rhs_mag, product;

    assign is_mul    = (bus.p4_op == OP_MUL);
    assign is_div    = (bus.p4_op == OP_DIVU) || (bus.p4_op == OP_DIVS) ||
                       (bus.p4_op == OP_MODU) || (bus.p4_op == OP_MODS);
    assign op_signed = (bus.p4_op == OP_DIVS) || (bus.p4_op == OP_MODS);
    assign op_mod    = (bus.p4_op == OP_MODU) || (bus.p4_op == OP_MODS);
    assign lhs_neg   = op_signed && bus.p4_lhs[WIDTH-1];
    assign rhs_neg   = op_signed && bus.p4_rhs[WIDTH-1];
    assign lhs_mag   = lhs_neg ? -bus.p4_lhs : bus.p4_lhs;
    assign rhs_mag   = rhs_neg ? -bus.p4_rhs : bus.p4_rhs;
    assign product   = bus.p4_lhs * bus.p4_rhs;

    // Restoring step: partial remainder is always below the divisor, so the
    // shifted value minus the divisor fits in WIDTH+1 bits and its top bit
    // is a clean borrow flag.
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic             fit;
    logic [WIDTH-1:0] rem_nx, quo_nx, quo_fin, rem_fin;

    assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, divisor_q};
    assign fit     = ~rem_sub[WIDTH];
    assign rem_nx  = fit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], fit};
    // most-negative / -1 falls out naturally: magnitude quotient is
    // 2^(WIDTH-1), and negating it gives the same bit pattern back
    assign quo_fin = q_neg_q ? -quo_nx : quo_nx;
    assign rem_fin = r_neg_q ? -rem_nx : rem_nx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            result    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            is_mod_q  <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        result <= product;
                        cnt    <= CW'(MUL_CYCLES - 1);
                        state  <= MUL;
                    end else if (is_div) begin
                        if (bus.p4_rhs == '0) begin
                            result <= op_mod ? bus.p4_lhs : '1;
                            state  <= DONE;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= lhs_mag;
                            divisor_q <= rhs_mag;
                            is_mod_q  <= op_mod;
                            q_neg_q   <= lhs_neg ^ rhs_neg;
                            r_neg_q   <= lhs_neg;
                            cnt       <= CW'(WIDTH - 1);
                            state     <= DIV;
                        end
                    end
                end
                MUL: begin
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (cnt == '0) begin
                        result <= is_mod_q ? rem_fin : quo_fin;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [7:0]    byte_v;
    logic [HW-1:0] half_v;

    assign byte_v = 8'(bus.p4_mem_rdata >> {bus.p4_addr_lo, 3'b000});
    assign half_v = HW'(bus.p4_mem_rdata >> (bus.p4_addr_lo[1] ? HW : 0));

    always_comb begin
        bus.p4_data_out = '0;
        bus.stall       = 1'b0;
        if (reset) begin
            bus.p4_data_out = '0;
        end else if (state == DONE) begin
            bus.p4_data_out = result;
        end else if (state != IDLE) begin
            bus.stall = 1'b1;
        end else if (is_mul || is_div) begin
            bus.stall = 1'b1;
        end else begin
            case (bus.p4_op)
                6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E:
                    bus.p4_data_out = bus.p4_alu_out;
                OP_LDW: begin
                    bus.p4_data_out = bus.p4_mem_rdata;
                    bus.stall       = bus.p4_read_pending;
                end
                OP_LDB: begin
                    bus.p4_data_out = WIDTH'($signed(byte_v));
                    bus.stall       = bus.p4_read_pending;
                end
                OP_LDBU: begin
                    bus.p4_data_out = WIDTH'(byte_v);
                    bus.stall       = bus.p4_read_pending;
                end
                OP_LDH: begin
                    bus.p4_data_out = WIDTH'($signed(half_v));
                    bus.stall       = bus.p4_read_pending;
                end
                OP_LDHU: begin
                    bus.p4_data_out = WIDTH'(half_v);
                    bus.stall       = bus.p4_read_pending;
                end
                OP_STW, OP_STB, OP_STH:
                    bus.stall = bus.p4_write_pending;
                default: bus.p4_data_out = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_completion_md.sv
module tb_cpu_completion_md;
    localparam logic [5:0] OP_ADD  = 6'h04, OP_LDW  = 6'h10, OP_LDB  = 6'h11,
                           OP_LDBU = 6'h12, OP_LDH  = 6'h13, OP_LDHU = 6'h14,
                           OP_STW  = 6'h18, OP_MUL  = 6'h20, OP_DIVU = 6'h21,
                           OP_DIVS = 6'h22, OP_MODU = 6'h23, OP_MODS = 6'h24,
                           OP_CFGR = 6'h28, OP_UNDEF = 6'h3F;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    cpu_completion_md_if #(.WIDTH(32)) bus ();

    cpu_completion_md #(.WIDTH(32), .MUL_CYCLES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic drive(input logic [5:0] op, input logic [31:0] alu);
        @(negedge clock);
        bus.p4_op      = op;
        bus.p4_alu_out = alu;
        #1;
    endtask

    // Issues one arithmetic op, scrambles operands while busy, and returns
    // the number of stall cycles and the value seen when stall drops.
    task automatic run_arith(input logic [5:0] op, input logic [31:0] lhs,
                             input logic [31:0] rhs, output int n,
                             output logic [31:0] res);
        @(negedge clock);
        bus.p4_op  = op;
        bus.p4_lhs = lhs;
        bus.p4_rhs = rhs;
        #1;
        n = 0;
        while (bus.stall === 1'b1 && n < 60) begin
            n++;
            @(negedge clock);
            bus.p4_lhs = $urandom;
            bus.p4_rhs = $urandom;
            #1;
        end
        res = bus.p4_data_out;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(OP_ADD, 32'h1234);
        checks++; if (bus.p4_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 00000000", bus.p4_data_out);
        end
        checks++; if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0", bus.stall);
        end
        drive(OP_MUL, 32'h1234);
        checks++; if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mul_stall: got %b want 0", bus.stall);
        end
        @(negedge clock);
        reset = 1'b0;
        bus.p4_op = OP_ADD;
        #1;
        checks++; if (bus.p4_data_out !== 32'h1234 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL add_after_reset: got %h/%b want 00001234/0",
                     bus.p4_data_out, bus.stall);
        end
    endtask

    task automatic test_alu_misc();
        bus.p4_write_pending = 1'b1;
        drive(OP_ADD, 32'hCAFE_0001);
        checks++; if (bus.p4_data_out !== 32'hCAFE_0001 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL add_pending_ignored: got %h/%b want cafe0001/0",
                     bus.p4_data_out, bus.stall);
        end
        bus.p4_write_pending = 1'b0;
        drive(OP_CFGR, 32'h5555_5555);
        checks++; if (bus.p4_data_out !== 32'h0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL cfgr: got %h/%b want 00000000/0", bus.p4_data_out, bus.stall);
        end
        drive(OP_UNDEF, 32'h5555_5555);
        checks++; if (bus.p4_data_out !== 32'h0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL undef_op: got %h/%b want 00000000/0", bus.p4_data_out, bus.stall);
        end
    endtask

    task automatic test_loads();
        logic [5:0]  ops [8] = '{OP_LDB, OP_LDBU, OP_LDH, OP_LDHU, OP_LDB,
                                 OP_LDB, OP_LDW, OP_LDH};
        logic [1:0]  alo [8] = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0};
        logic [31:0] exp [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                 32'h000080FF, 32'h00000001, 32'h0000007F,
                                 32'h80FF7F01, 32'h00007F01};
        bus.p4_mem_rdata = 32'h80FF7F01;
        for (int i = 0; i < 8; i++) begin
            bus.p4_addr_lo = alo[i];
            drive(ops[i], 32'hDEAD_BEEF);
            checks++; if (bus.p4_data_out !== exp[i] || bus.stall !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d: got %h/%b want %h/0", i,
                         bus.p4_data_out, bus.stall, exp[i]);
            end
        end
    endtask

    task automatic test_mem_pending();
        int n = 0;
        bus.p4_addr_lo = 2'd3;
        bus.p4_read_pending = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) bus.p4_read_pending = 1'b0;
            drive(OP_LDB, 32'h0);
            if (bus.stall === 1'b1) n++;
        end
        checks++; if (n !== 3) begin
            errors++;
            $display("FAIL read_pending_stall: got %0d cycles want 3", n);
        end
        checks++; if (bus.p4_data_out !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL load_after_pending: got %h want ffffff80", bus.p4_data_out);
        end
        bus.p4_write_pending = 1'b1;
        drive(OP_STW, 32'h1111);
        checks++; if (bus.stall !== 1'b1 || bus.p4_data_out !== 32'h0) begin
            errors++;
            $display("FAIL store_pending: got %b/%h want 1/00000000",
                     bus.stall, bus.p4_data_out);
        end
        bus.p4_write_pending = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.p4_data_out !== 32'h0) begin
            errors++;
            $display("FAIL store_done: got %b/%h want 0/00000000",
                     bus.stall, bus.p4_data_out);
        end
    endtask

    task automatic test_mul();
        int n; logic [31:0] r;
        bus.p4_read_pending = 1'b1;
        run_arith(OP_MUL, 32'hFFFFFFFF, 32'd3, n, r);
        bus.p4_read_pending = 1'b0;
        checks++; if (n !== 3) begin
            errors++;
            $display("FAIL mul_stall: got %0d want 3", n);
        end
        checks++; if (r !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL mul_result: got %h want fffffffd", r);
        end
        drive(OP_ADD, 32'h77);
        checks++; if (bus.p4_data_out !== 32'h77 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL after_mul: got %h/%b want 00000077/0", bus.p4_data_out, bus.stall);
        end
    endtask

    task automatic test_div();
        logic [5:0]  ops [10] = '{OP_DIVS, OP_MODS, OP_DIVU, OP_MODU, OP_DIVS,
                                  OP_MODS, OP_DIVU, OP_MODU, OP_DIVS, OP_MODS};
        logic [31:0] lh [10] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7,
                                 32'd7, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] rh [10] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE,
                                 32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD,
                                 32'd1, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int          st [10] = '{33, 33, 33, 33, 33, 33, 1, 1, 33, 33};
        int n; logic [31:0] r;
        for (int i = 0; i < 10; i++) begin
            run_arith(ops[i], lh[i], rh[i], n, r);
            checks++; if (n !== st[i] || r !== ex[i]) begin
                errors++;
                $display("FAIL div_%0d: got %h after %0d stalls want %h after %0d",
                         i, r, n, ex[i], st[i]);
            end
            drive(OP_ADD, 32'h0);
        end
        run_arith(OP_MODS, 32'hFFFFFFF9, 32'd0, n, r);
        checks++; if (n !== 1 || r !== 32'hFFFFFFF9) begin
            errors++;
            $display("FAIL mods_by_zero: got %h after %0d want fffffff9 after 1", r, n);
        end
        drive(OP_ADD, 32'h0);
    endtask

    task automatic test_back_to_back();
        int n; logic [31:0] r;
        run_arith(OP_MUL, 32'd6, 32'd7, n, r);
        checks++; if (n !== 3 || r !== 32'd42) begin
            errors++;
            $display("FAIL b2b_first: got %h after %0d want 0000002a after 3", r, n);
        end
        bus.p4_lhs = 32'd5;
        bus.p4_rhs = 32'd5;
        run_arith(OP_MUL, 32'd5, 32'd5, n, r);
        checks++; if (n !== 3 || r !== 32'd25) begin
            errors++;
            $display("FAIL b2b_second: got %h after %0d want 00000019 after 3", r, n);
        end
        drive(OP_ADD, 32'h9);
        checks++; if (bus.p4_data_out !== 32'h9 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse: got %h/%b want 00000009/0", bus.p4_data_out, bus.stall);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen = 0;
        @(negedge clock);
        bus.p4_op  = OP_DIVS;
        bus.p4_lhs = 32'hFFFFFFF9;
        bus.p4_rhs = 32'd2;
        for (int i = 0; i < 10; i++) @(negedge clock);
        reset = 1'b1;
        bus.p4_op = OP_ADD;
        bus.p4_alu_out = 32'h55;
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.p4_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_op: got %b/%h want 0/00000000",
                     bus.stall, bus.p4_data_out);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.stall !== 1'b0 || bus.p4_data_out !== 32'h55) seen++;
            @(negedge clock);
        end
        checks++; if (seen !== 0) begin
            errors++;
            $display("FAIL add_after_abort: got %0d bad cycles want 0", seen);
        end
    endtask

    initial begin
        bus.p4_op = 6'h0; bus.p4_alu_out = '0; bus.p4_lhs = '0; bus.p4_rhs = '0;
        bus.p4_addr_lo = '0; bus.p4_write_pending = 1'b0; bus.p4_read_pending = 1'b0;
        bus.p4_mem_rdata = '0;
        test_reset();
        test_alu_misc();
        test_loads();
        test_mem_pending();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
